// File: rtl/dma_channel_arbiter.sv
// -----------------------------------------------------------------------------
// dma_channel_arbiter
//
// Shares the single device-side port of the DMA controller between NUM_CH
// requesting peripherals. One channel at a time is granted in round-robin
// order. The granted channel's configuration is presented to the controller
// together with a single-cycle rqst. The grant is then held until the
// controller signals completion with end_flag.
//
// Ports
//   clk, reset            : clock, asynchronous active-low reset
//   ch_req / ch_mask      : per-channel level request and enable
//   ch_num_words          : flat per-channel word count (ADD_LEN each)
//   ch_start_addr         : flat per-channel start address (ADD_LEN+1 each)
//   ch_rd_wr              : per-channel direction (1 = memory-to-device)
//   ch_dev_ack, ch_dev_in : per-channel device ack and write data
//   ch_grant              : one-hot grant, ISSUE through RELEASE
//   ch_dma_ack            : controller dma_ack routed to the granted channel
//   ch_dev_out            : controller dev_out, broadcast to all channels
//   ch_end                : one-cycle completion pulse to the granted channel
//   busy, grant_id        : arbiter activity and current/most recent winner
//   rqst .. dev_in        : request and configuration towards the controller
//   dma_ack, dev_out,
//   end_flag              : handshake and status from the controller
// -----------------------------------------------------------------------------
module dma_channel_arbiter #(
    parameter int NUM_CH   = 4,
    parameter int ADD_LEN  = 16,
    parameter int DATA_LEN = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH-1:0]            ch_mask,
    input  logic [NUM_CH*ADD_LEN-1:0]    ch_num_words,
    input  logic [NUM_CH*(ADD_LEN+1)-1:0] ch_start_addr,
    input  logic [NUM_CH-1:0]            ch_rd_wr,
    input  logic [NUM_CH-1:0]            ch_dev_ack,
    input  logic [NUM_CH*DATA_LEN-1:0]   ch_dev_in,
    output logic [NUM_CH-1:0]            ch_grant,
    output logic [NUM_CH-1:0]            ch_dma_ack,
    output logic [DATA_LEN-1:0]          ch_dev_out,
    output logic [NUM_CH-1:0]            ch_end,
    output logic                         busy,
    output logic [2:0]                   grant_id,
    output logic                         rqst,
    output logic [ADD_LEN-1:0]           num_words,
    output logic [ADD_LEN:0]             start_addr,
    output logic                         rd_wr,
    output logic                         dev_ack,
    output logic [DATA_LEN-1:0]          dev_in,
    input  logic                         dma_ack,
    input  logic [DATA_LEN-1:0]          dev_out,
    input  logic                         end_flag
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_XFER,
        ST_RELEASE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [2:0]          last;
    logic [2:0]          winner;
    logic                found;
    logic [NUM_CH-1:0]   eligible;
    logic                active;

    assign eligible   = ch_req & ch_mask;
    assign active     = (state != ST_IDLE);
    assign busy       = active;
    assign rqst       = (state == ST_ISSUE);
    assign ch_dev_out = dev_out;

    // Round-robin search: the candidate at distance k above 'last' (modulo
    // NUM_CH) wins if it is the nearest eligible one. The inner loop walks
    // constant channel indices so the vector selects stay static.
    always_comb begin
        winner = last;
        found  = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (!found && eligible[j] && (j == ((int'(last) + k) % NUM_CH))) begin
                    winner = 3'(j);
                    found  = 1'b1;
                end
            end
        end
    end

    // Next-state logic. Only IDLE looks at requests, so a granted transfer
    // cannot be revoked by request or mask changes, and end_flag is only
    // honoured while the controller is actually transferring.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (eligible != '0) state_next = ST_ISSUE;
            ST_ISSUE:   state_next = ST_XFER;
            ST_XFER:    if (end_flag) state_next = ST_RELEASE;
            ST_RELEASE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // State register plus the winner capture. grant_id and last are only
    // written on the IDLE->ISSUE edge so they stay constant for the whole
    // transaction and grant_id keeps the previous winner while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            grant_id <= '0;
            last     <= 3'(NUM_CH - 1);
        end else begin
            state <= state_next;
            if (state == ST_IDLE && eligible != '0) begin
                grant_id <= winner;
                last     <= winner;
            end
        end
    end

    // Output routing from state and grant_id. Configuration is held for the
    // whole grant because the controller latches it one cycle after rqst;
    // the handshake only passes through while the controller is in XFER.
    always_comb begin
        ch_grant   = '0;
        ch_dma_ack = '0;
        ch_end     = '0;
        num_words  = '0;
        start_addr = '0;
        rd_wr      = 1'b0;
        dev_in     = '0;
        dev_ack    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (active && grant_id == 3'(i)) begin
                ch_grant[i] = 1'b1;
                num_words   = ch_num_words[i*ADD_LEN +: ADD_LEN];
                start_addr  = ch_start_addr[i*(ADD_LEN+1) +: ADD_LEN+1];
                rd_wr       = ch_rd_wr[i];
                dev_in      = ch_dev_in[i*DATA_LEN +: DATA_LEN];
                if (state == ST_XFER) begin
                    dev_ack       = ch_dev_ack[i];
                    ch_dma_ack[i] = dma_ack;
                end
                if (state == ST_RELEASE) begin
                    ch_end[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dma_channel_arbiter
//
// Self-checking bench for dma_channel_arbiter (NUM_CH = 4). Expected grant
// winners are pushed to a queue when requests are driven and popped by a
// monitor whenever rqst is seen, where the grant and the presented
// configuration are compared against the bench's own channel settings.
// A small controller model answers each rqst with end_flag after
// num_words+2 cycles when automatic mode is enabled.
// -----------------------------------------------------------------------------
module tb_dma_channel_arbiter;

    localparam int NUM_CH   = 4;
    localparam int ADD_LEN  = 16;
    localparam int DATA_LEN = 16;

    logic                          clk;
    logic                          reset;
    logic [NUM_CH-1:0]             ch_req;
    logic [NUM_CH-1:0]             ch_mask;
    logic [NUM_CH*ADD_LEN-1:0]     ch_num_words;
    logic [NUM_CH*(ADD_LEN+1)-1:0] ch_start_addr;
    logic [NUM_CH-1:0]             ch_rd_wr;
    logic [NUM_CH-1:0]             ch_dev_ack;
    logic [NUM_CH*DATA_LEN-1:0]    ch_dev_in;
    logic [NUM_CH-1:0]             ch_grant;
    logic [NUM_CH-1:0]             ch_dma_ack;
    logic [DATA_LEN-1:0]           ch_dev_out;
    logic [NUM_CH-1:0]             ch_end;
    logic                          busy;
    logic [2:0]                    grant_id;
    logic                          rqst;
    logic [ADD_LEN-1:0]            num_words;
    logic [ADD_LEN:0]              start_addr;
    logic                          rd_wr;
    logic                          dev_ack;
    logic [DATA_LEN-1:0]           dev_in;
    logic                          dma_ack;
    logic [DATA_LEN-1:0]           dev_out;
    logic                          end_flag;

    // Per-channel configuration owned by the bench; the flat DUT buses are
    // built from these so the monitor can compare against them directly.
    logic [ADD_LEN-1:0]  cfg_nw  [NUM_CH];
    logic [ADD_LEN:0]    cfg_sa  [NUM_CH];
    logic [DATA_LEN-1:0] cfg_din [NUM_CH];

    int       n_compared = 0;
    int       n_failed   = 0;
    bit       auto_ctrl  = 0;
    logic [2:0] exp_q[$];

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_pack
            assign ch_num_words[g*ADD_LEN +: ADD_LEN]       = cfg_nw[g];
            assign ch_start_addr[g*(ADD_LEN+1) +: ADD_LEN+1] = cfg_sa[g];
            assign ch_dev_in[g*DATA_LEN +: DATA_LEN]        = cfg_din[g];
        end
    endgenerate

    dma_channel_arbiter #(
        .NUM_CH   (NUM_CH),
        .ADD_LEN  (ADD_LEN),
        .DATA_LEN (DATA_LEN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ch_req        (ch_req),
        .ch_mask       (ch_mask),
        .ch_num_words  (ch_num_words),
        .ch_start_addr (ch_start_addr),
        .ch_rd_wr      (ch_rd_wr),
        .ch_dev_ack    (ch_dev_ack),
        .ch_dev_in     (ch_dev_in),
        .ch_grant      (ch_grant),
        .ch_dma_ack    (ch_dma_ack),
        .ch_dev_out    (ch_dev_out),
        .ch_end        (ch_end),
        .busy          (busy),
        .grant_id      (grant_id),
        .rqst          (rqst),
        .num_words     (num_words),
        .start_addr    (start_addr),
        .rd_wr         (rd_wr),
        .dev_ack       (dev_ack),
        .dev_in        (dev_in),
        .dma_ack       (dma_ack),
        .dev_out       (dev_out),
        .end_flag      (end_flag)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it and reports a failing one.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_CH-1:0] req, input logic [NUM_CH-1:0] mask);
        ch_req  = req;
        ch_mask = mask;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        applyStimulus('0, '1);
        end_flag = 1'b0;
        dma_ack  = 1'b0;
        step();
        step();
        exp_q.delete();
        reset = 1'b1;
    endtask

    task automatic wait_rqst(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (rqst) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) checkOutput("rqst_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_end(input int limit, output logic [NUM_CH-1:0] seen);
        seen = '0;
        for (int i = 0; i < limit; i++) begin
            if (ch_end != '0) begin
                seen = ch_end;
                break;
            end
            step();
        end
        if (seen == '0) checkOutput("end_timeout", 32'd0, 32'd1);
    endtask

    // Controller model: once rqst is seen, end_flag rises num_words+2 cycles
    // later for one cycle, giving ISSUE, XFER x (n+2), RELEASE.
    initial begin
        int nw;
        end_flag = 1'b0;
        forever begin
            @(negedge clk);
            if (rqst && auto_ctrl) begin
                nw = int'(num_words);
                repeat (nw + 2) @(posedge clk);
                #1;
                end_flag = 1'b1;
                @(posedge clk);
                #1;
                end_flag = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every rqst pops the expected winner and checks the
    // grant, the presented configuration, single-cycle rqst, and that the
    // previous transfer ended with a ch_end and a sufficient rqst-low gap.
    initial begin
        logic [2:0] id;
        bit prev_rqst = 1'b0;
        bit have_prev = 1'b0;
        bit end_seen  = 1'b0;
        int low_count = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                have_prev = 1'b0;
                end_seen  = 1'b0;
                low_count = 0;
            end else if (rqst) begin
                checkOutput("rqst_single_cycle", 32'(prev_rqst), 32'd0);
                if (have_prev) begin
                    checkOutput("end_before_next_rqst", 32'(end_seen), 32'd1);
                    checkOutput("rqst_low_gap_ge3", 32'(low_count >= 3), 32'd1);
                end
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_rqst", 32'd1, 32'd0);
                end else begin
                    id = exp_q.pop_front();
                    checkOutput("sb_grant_id", 32'(grant_id), 32'(id));
                    checkOutput("sb_ch_grant", 32'(ch_grant), 32'd1 << id);
                    checkOutput("sb_num_words", 32'(num_words), 32'(cfg_nw[id]));
                    checkOutput("sb_start_addr", 32'(start_addr), 32'(cfg_sa[id]));
                    checkOutput("sb_rd_wr", 32'(rd_wr), 32'(ch_rd_wr[id]));
                    checkOutput("sb_dev_in", 32'(dev_in), 32'(cfg_din[id]));
                end
                have_prev = 1'b1;
                end_seen  = 1'b0;
                low_count = 0;
            end else begin
                low_count++;
                if (ch_end != '0) end_seen = 1'b1;
            end
            prev_rqst = rqst;
        end
    end

    typedef struct {
        logic [NUM_CH-1:0] req;
        logic [NUM_CH-1:0] mask;
        logic [2:0]        exp_id;
    } vec_t;

    vec_t vecs[10];

    // Main test sequence.
    initial begin
        bit ok;
        logic [NUM_CH-1:0] seen;

        // Round-robin expectation table, starting from a fresh reset (last = 3).
        vecs[0] = '{4'b0100, 4'b1111, 3'd2};
        vecs[1] = '{4'b1111, 4'b1111, 3'd3};
        vecs[2] = '{4'b1111, 4'b1111, 3'd0};
        vecs[3] = '{4'b0011, 4'b1110, 3'd1};
        vecs[4] = '{4'b0001, 4'b1111, 3'd0};
        vecs[5] = '{4'b1001, 4'b0111, 3'd0};
        vecs[6] = '{4'b0110, 4'b1111, 3'd1};
        vecs[7] = '{4'b0101, 4'b1111, 3'd2};
        vecs[8] = '{4'b1000, 4'b1111, 3'd3};
        vecs[9] = '{4'b1111, 4'b1111, 3'd0};

        for (int i = 0; i < NUM_CH; i++) begin
            cfg_sa[i]  = 17'(17'h100 * (i + 1) + i);
            cfg_din[i] = 16'(16'hA000 + i);
        end
        cfg_nw[0] = 16'd2;
        cfg_nw[1] = 16'd1;
        cfg_nw[2] = 16'd3;
        cfg_nw[3] = 16'd4;
        ch_rd_wr   = 4'b0101;
        ch_dev_ack = 4'b0000;
        dev_out    = 16'h5A5A;
        dma_ack    = 1'b0;
        reset      = 1'b1;
        applyStimulus('0, '1);

        // Reset values.
        do_reset();
        reset = 1'b0;
        #1;
        checkOutput("reset_rqst", 32'(rqst), 32'd0);
        checkOutput("reset_ch_grant", 32'(ch_grant), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_grant_id", 32'(grant_id), 32'd0);
        checkOutput("reset_num_words", 32'(num_words), 32'd0);
        checkOutput("reset_start_addr", 32'(start_addr), 32'd0);
        checkOutput("reset_ch_end", 32'(ch_end), 32'd0);
        checkOutput("reset_dev_out_passthru", 32'(ch_dev_out), 32'h5A5A);
        step();
        reset = 1'b1;

        // end_flag while idle must not start anything.
        end_flag = 1'b1;
        step();
        step();
        end_flag = 1'b0;
        checkOutput("idle_end_flag_ignored", 32'(busy), 32'd0);

        // Continuous requests from all channels: order 0,1,2,3,0.
        $display("[TB] round-robin with all channels requesting");
        do_reset();
        auto_ctrl = 1'b1;
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd0);
        applyStimulus(4'b1111, 4'b1111);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        checkOutput("rr_all_grants_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        applyStimulus(4'b0000, 4'b1111);
        wait_end(40, seen);
        checkOutput("rr_last_end", 32'(seen), 32'b0001);
        step();
        checkOutput("rr_idle", 32'(busy), 32'd0);

        // Table-driven transactions; requests are withdrawn once in XFER.
        $display("[TB] table-driven arbitration vectors");
        do_reset();
        auto_ctrl = 1'b1;
        for (int v = 0; v < 10; v++) begin
            exp_q.push_back(vecs[v].exp_id);
            applyStimulus(vecs[v].req, vecs[v].mask);
            wait_rqst(40, ok);
            step();
            applyStimulus(4'b0000, vecs[v].mask);
            wait_end(40, seen);
            checkOutput("tbl_ch_end", 32'(seen), 32'd1 << vecs[v].exp_id);
            step();
            checkOutput("tbl_idle", 32'(busy), 32'd0);
        end

        // Single request on channel 2 (3 words, memory-to-device): config
        // must hold steady until completion.
        $display("[TB] single request on channel 2");
        exp_q.push_back(3'd2);
        applyStimulus(4'b0100, 4'b1111);
        wait_rqst(40, ok);
        step();
        applyStimulus(4'b0000, 4'b1111);
        seen = '0;
        for (int i = 0; i < 20; i++) begin
            if (ch_end != '0) begin
                seen = ch_end;
                break;
            end
            checkOutput("single_no_rqst_in_xfer", 32'(rqst), 32'd0);
            checkOutput("single_num_words_stable", 32'(num_words), 32'd3);
            checkOutput("single_start_addr_stable", 32'(start_addr), 32'(cfg_sa[2]));
            step();
        end
        checkOutput("single_ch_end", 32'(seen), 32'b0100);
        checkOutput("single_release_config", 32'(num_words), 32'd3);
        step();
        checkOutput("single_idle_config_zero", 32'(num_words), 32'd0);

        // Handshake routing for channel 3 with a manually driven controller.
        $display("[TB] handshake routing on channel 3");
        auto_ctrl = 1'b0;
        do_reset();
        exp_q.push_back(3'd3);
        applyStimulus(4'b1000, 4'b1111);
        wait_rqst(40, ok);
        ch_dev_ack = 4'b1000;
        #1;
        checkOutput("hs_dev_ack_issue", 32'(dev_ack), 32'd0);
        step();
        applyStimulus(4'b0000, 4'b1111);
        ch_dev_ack = 4'b0001;
        #1;
        checkOutput("hs_dev_ack_ch0_only", 32'(dev_ack), 32'd0);
        ch_dev_ack = 4'b1000;
        #1;
        checkOutput("hs_dev_ack_ch3", 32'(dev_ack), 32'd1);
        ch_dev_ack = 4'b1001;
        #1;
        checkOutput("hs_dev_ack_ch3_ch0", 32'(dev_ack), 32'd1);
        dma_ack = 1'b1;
        dev_out = 16'hC3C3;
        #1;
        checkOutput("hs_ch_dma_ack", 32'(ch_dma_ack), 32'b1000);
        checkOutput("hs_ch_dev_out", 32'(ch_dev_out), 32'hC3C3);
        step();
        dma_ack = 1'b0;
        #1;
        checkOutput("hs_ch_dma_ack_low", 32'(ch_dma_ack), 32'd0);
        dma_ack = 1'b1;
        #1;
        checkOutput("hs_ch_dma_ack_again", 32'(ch_dma_ack), 32'b1000);
        dma_ack  = 1'b0;
        end_flag = 1'b1;
        step();
        end_flag = 1'b0;
        checkOutput("hs_ch_end", 32'(ch_end), 32'b1000);
        checkOutput("hs_dev_ack_release", 32'(dev_ack), 32'd0);
        checkOutput("hs_grant_release", 32'(ch_grant), 32'b1000);
        step();
        checkOutput("hs_idle", 32'(busy), 32'd0);
        ch_dev_ack = 4'b0000;

        // Zero-word transfer on channel 1 with the request dropped in XFER.
        $display("[TB] zero-word transfer on channel 1");
        auto_ctrl = 1'b1;
        cfg_nw[1] = 16'd0;
        exp_q.push_back(3'd1);
        applyStimulus(4'b0010, 4'b1111);
        wait_rqst(40, ok);
        step();
        checkOutput("zero_xfer1_busy", 32'(busy && !rqst), 32'd1);
        applyStimulus(4'b0000, 4'b1111);
        step();
        checkOutput("zero_xfer2_no_end", 32'(ch_end), 32'd0);
        checkOutput("zero_xfer2_grant_held", 32'(ch_grant), 32'b0010);
        step();
        checkOutput("zero_release_end", 32'(ch_end), 32'b0010);
        step();
        checkOutput("zero_idle", 32'(busy), 32'd0);

        // Reset in the middle of a transfer, then channel 1 wins first.
        $display("[TB] reset during transfer");
        auto_ctrl = 1'b0;
        do_reset();
        exp_q.push_back(3'd0);
        applyStimulus(4'b0001, 4'b1111);
        wait_rqst(40, ok);
        step();
        checkOutput("rst_mid_busy_before", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_rqst", 32'(rqst), 32'd0);
        checkOutput("rst_mid_grant", 32'(ch_grant), 32'd0);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_num_words", 32'(num_words), 32'd0);
        checkOutput("rst_mid_grant_id", 32'(grant_id), 32'd0);
        applyStimulus(4'b1010, 4'b1111);
        step();
        step();
        reset = 1'b1;
        checkOutput("rst_release_no_grant_yet", 32'(busy), 32'd0);
        exp_q.push_back(3'd1);
        wait_rqst(40, ok);
        checkOutput("rst_first_grant_id", 32'(grant_id), 32'd1);
        step();
        applyStimulus(4'b0000, 4'b1111);
        end_flag = 1'b1;
        step();
        end_flag = 1'b0;
        checkOutput("rst_ch_end", 32'(ch_end), 32'b0010);
        step();

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
